// File: rtl/multiplicador_seq.sv
// Sequential unsigned 32x32 -> 64 shift-and-add multiplier built around a
// 32-bit ripple-carry adder; one multiplier bit is consumed per clock.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module ripple_carry_adder (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] Soma,
  output logic        Cout
);
  logic [32:0] carry;

  assign carry[0] = Cin;
  assign Cout     = carry[32];

  for (genvar i = 0; i < 32; i++) begin : g_bit
    full_adder u_fa (
      .a   (A[i]),
      .b   (B[i]),
      .cin (carry[i]),
      .s   (Soma[i]),
      .cout(carry[i+1])
    );
  end
endmodule

module multiplicador_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        inicio,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        ocupado,
  output logic        pronto,
  output logic [63:0] Produto
);
  typedef enum logic [1:0] {OCIOSO, CALC, FIM} estado_t;

  estado_t     estado, prox;
  logic [31:0] M, P_hi, P_lo;
  logic [4:0]  cont;
  logic [31:0] parcela, soma;
  logic        cout;

  // Partial product is either the multiplicand or zero, chosen by the
  // multiplier bit about to be shifted out.
  assign parcela = P_lo[0] ? M : 32'd0;

  ripple_carry_adder u_rca (
    .A   (P_hi),
    .B   (parcela),
    .Cin (1'b0),
    .Soma(soma),
    .Cout(cout)
  );

  assign Produto = {P_hi, P_lo};

  always_comb begin
    prox    = estado;
    ocupado = 1'b0;
    pronto  = 1'b0;
    case (estado)
      OCIOSO: if (inicio) prox = CALC;
      CALC: begin
        ocupado = 1'b1;
        if (cont == 5'd31) prox = FIM;
      end
      FIM: begin
        pronto = 1'b1;
        prox   = OCIOSO;
      end
      default: prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= OCIOSO;
      M      <= '0;
      P_hi   <= '0;
      P_lo   <= '0;
      cont   <= '0;
    end else begin
      estado <= prox;
      case (estado)
        OCIOSO: if (inicio) begin
          M    <= A;
          P_hi <= '0;
          P_lo <= B;
          cont <= '0;
        end
        CALC: begin
          // 65-bit {carry, sum, multiplier} shifted right by one
          {P_hi, P_lo} <= {cout, soma, P_lo[31:1]};
          cont         <= cont + 5'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multiplicador_seq.sv
// Randomized self-checking bench for multiplicador_seq against a plain
// 64-bit multiply reference, with cycle-exact latency checks.

module tb_multiplicador_seq;
  logic        clock = 1'b0;
  logic        reset;
  logic        inicio;
  logic [31:0] A, B;
  logic        ocupado, pronto;
  logic [63:0] Produto;

  int checks   = 0;
  int failures = 0;

  multiplicador_seq dut (
    .clock  (clock),
    .reset  (reset),
    .inicio (inicio),
    .A      (A),
    .B      (B),
    .ocupado(ocupado),
    .pronto (pronto),
    .Produto(Produto)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Full operation: start in the current (idle) cycle, optionally poke inicio
  // during CALC cycle glitch_cyc and/or in the FIM cycle. Returns in cycle 34.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int glitch_cyc, input bit glitch_fim);
    logic [63:0] exp;
    exp    = {32'd0, a} * {32'd0, b};
    inicio = 1'b1; A = a; B = b;
    tick();
    for (int cyc = 1; cyc <= 32; cyc++) begin
      chk("ocupado_calc", {63'd0, ocupado}, 64'd1);
      chk("pronto_calc",  {63'd0, pronto},  64'd0);
      inicio = (cyc == glitch_cyc);
      A = (cyc == glitch_cyc) ? 32'd1 : $urandom;
      B = (cyc == glitch_cyc) ? 32'd1 : $urandom;
      tick();
    end
    chk("pronto_fim",  {63'd0, pronto},  64'd1);
    chk("ocupado_fim", {63'd0, ocupado}, 64'd0);
    chk("produto",     Produto,          exp);
    inicio = glitch_fim; A = 32'd1; B = 32'd1;
    tick();
    inicio = 1'b0;
    chk("ocupado_idle", {63'd0, ocupado}, 64'd0);
    chk("pronto_idle",  {63'd0, pronto},  64'd0);
    chk("produto_hold", Produto,          exp);
  endtask

  initial begin
    reset = 1'b1; inicio = 1'b0; A = '0; B = '0;
    tick(); tick();
    chk("rst_ocupado", {63'd0, ocupado}, 64'd0);
    chk("rst_pronto",  {63'd0, pronto},  64'd0);
    chk("rst_produto", Produto,          64'd0);
    reset = 1'b0;
    tick();

    run_op(32'd3, 32'd5, 0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(32'h1234_5678, 32'd0, 0, 1'b0);
    run_op(32'h8000_0000, 32'd2, 0, 1'b0);
    run_op(32'd7, 32'd9, 10, 1'b1);

    // Idle hold with inicio low: product must stay put
    for (int i = 0; i < 3; i++) tick();
    chk("idle_hold", Produto, 64'd63);

    // Reset in mid-CALC
    inicio = 1'b1; A = 32'hDEAD_BEEF; B = 32'h0000_1000;
    tick();
    inicio = 1'b0;
    for (int cyc = 1; cyc < 15; cyc++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_ocupado", {63'd0, ocupado}, 64'd0);
    chk("midrst_pronto",  {63'd0, pronto},  64'd0);
    chk("midrst_produto", Produto,          64'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        if (pronto) seen++;
        tick();
      end
      chk("midrst_no_pronto", 64'(seen), 64'd0);
    end

    // Reset beats inicio on the same edge
    reset = 1'b1; inicio = 1'b1; A = 32'd5; B = 32'd5;
    tick();
    reset = 1'b0; inicio = 1'b0;
    chk("rst_prio_ocupado", {63'd0, ocupado}, 64'd0);
    chk("rst_prio_produto", Produto,          64'd0);

    run_op(32'd6, 32'd7, 0, 1'b0);

    // Back-to-back random operands, each started in the first idle cycle
    for (int n = 0; n < 100; n++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'hFFFF_FFFF;
        1: b = 32'd0;
        2: b = 32'h8000_0000;
        default: ;
      endcase
      run_op(a, b, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
